// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
//   Shared constants for the pipelined approximate multiplier.
//   Quadrant indices double as bit positions in the per-operation mode word:
//     Q_LL = A_lo*B_lo, Q_LH = A_lo*B_hi, Q_HL = A_hi*B_lo, Q_HH = A_hi*B_hi.
//   A mode bit of 1 makes that quadrant approximate (low TRUNC bits cleared).
package approx_mult_pkg;

  localparam int MODE_W = 4;

  localparam int Q_LL = 0;
  localparam int Q_LH = 1;
  localparam int Q_HL = 2;
  localparam int Q_HH = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_EXACT      = 4'h0;
  localparam mode_t MODE_ALL_APPROX = 4'hF;

  // Operand half feeding a quadrant: 0 = low half, 1 = high half.
  // Bit 1 of the quadrant index picks the A half, bit 0 picks the B half.
  function automatic int quad_a_half(input int q);
    return q / 2;
  endfunction

  function automatic int quad_b_half(input int q);
    return q % 2;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// approx_mult_pipe_if
//   Operand and result channels of approx_mult_pipe, both valid/ready.
//   Operand channel : in_valid, in_ready, in_a, in_b, in_mode, in_tag
//   Result channel  : out_valid, out_ready, out_r, out_tag
//   Modports: slave = the multiplier, master = the producer/consumer side.
interface approx_mult_pipe_if
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  mode_t            in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_r;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag
  );

endinterface

// File: rtl/approx_quad_mul.sv
// approx_quad_mul
//   Combinational HW x HW unsigned multiplier for one quadrant.
//   Ports: a, b (HW bits) operands; approx = 1 clears the low TRUNC bits
//   of the product; q (2*HW bits) quadrant product.
module approx_quad_mul #(
  parameter int HW    = 4,
  parameter int TRUNC = 2
) (
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  input  logic            approx,
  output logic [2*HW-1:0] q
);

  // TRUNC = 0 leaves the mask all ones, so approximate equals exact.
  localparam logic [2*HW-1:0] KEEP_MASK = {(2*HW){1'b1}} << TRUNC;

  logic [2*HW-1:0] prod;

  assign prod = {{HW{1'b0}}, a} * {{HW{1'b0}}, b};
  assign q    = approx ? (prod & KEEP_MASK) : prod;

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Three-stage pipelined W x W approximate multiplier built from four
//   (W/2)x(W/2) quadrant products, each exact or approximate per in_mode.
//     S1: operands, mode, tag   S2: quadrant products   S3: summed result
//   One global stall: every stage advances when the output is empty or
//   being accepted, so in_ready = !out_valid || out_ready.
//   Ports: clk, rst (async, active high); bus (approx_mult_pipe_if.slave).
//   Optional (APPROX_MULT_ERR_MON_EN defined):
//     err_abs (2W) exact product minus out_r, aligned with out_r;
//     err_cnt (32) saturating count of output transfers with err_abs != 0.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int TRUNC = 2,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  approx_mult_pipe_if.slave   bus
`ifdef APPROX_MULT_ERR_MON_EN
  ,
  output logic [2*W-1:0]      err_abs,
  output logic [31:0]         err_cnt
`endif
);

  localparam int HW = W / 2;

  logic advance;

  // Stage 1
  logic             s1_valid_reg;
  logic [W-1:0]     s1_a_reg;
  logic [W-1:0]     s1_b_reg;
  mode_t            s1_mode_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  // Stage 2
  logic                       s2_valid_reg;
  logic [MODE_W-1:0][W-1:0]   s2_quad;
  logic [TAG_W-1:0]           s2_tag_reg;

  // Stage 3
  logic                 s3_valid_reg;
  logic [2*W-1:0]       s3_r_reg;
  logic [TAG_W-1:0]     s3_tag_reg;
  logic [W:0]           mid_sum;
  logic [2*W-1:0]       sum_next;

  assign advance      = !s3_valid_reg || bus.out_ready;
  assign bus.in_ready = advance;

  // ---------------- S1: capture operands with their mode and tag -------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_mode_reg  <= MODE_EXACT;
      s1_tag_reg   <= '0;
    end else if (advance) begin
      s1_valid_reg <= bus.in_valid;
      s1_a_reg     <= bus.in_a;
      s1_b_reg     <= bus.in_b;
      s1_mode_reg  <= bus.in_mode;
      s1_tag_reg   <= bus.in_tag;
    end
  end

  // ---------------- S2: four quadrant products -------------------------------
  for (genvar gi = 0; gi < MODE_W; gi++) begin : g_quad
    localparam int AH = quad_a_half(gi);
    localparam int BH = quad_b_half(gi);

    logic [W-1:0] quad_next;
    logic [W-1:0] quad_reg;

    approx_quad_mul #(
      .HW    (HW),
      .TRUNC (TRUNC)
    ) u_quad (
      .a      (s1_a_reg[AH*HW +: HW]),
      .b      (s1_b_reg[BH*HW +: HW]),
      .approx (s1_mode_reg[gi]),
      .q      (quad_next)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        quad_reg <= '0;
      end else if (advance) begin
        quad_reg <= quad_next;
      end
    end

    assign s2_quad[gi] = quad_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_tag_reg   <= '0;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
      s2_tag_reg   <= s1_tag_reg;
    end
  end

  // ---------------- S3: recombine quadrants ----------------------------------
  // The true sum never exceeds (2^W-1)^2, so the carry out of bit 2W-1 is
  // always zero and the sum is formed directly at 2W bits.
  always_comb begin
    mid_sum  = {1'b0, s2_quad[Q_LH]} + {1'b0, s2_quad[Q_HL]};
    sum_next = {s2_quad[Q_HH], {W{1'b0}}}
             + {{(HW-1){1'b0}}, mid_sum, {HW{1'b0}}}
             + {{W{1'b0}}, s2_quad[Q_LL]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_reg <= 1'b0;
      s3_r_reg     <= '0;
      s3_tag_reg   <= '0;
    end else if (advance) begin
      s3_valid_reg <= s2_valid_reg;
      s3_r_reg     <= sum_next;
      s3_tag_reg   <= s2_tag_reg;
    end
  end

  assign bus.out_valid = s3_valid_reg;
  assign bus.out_r     = s3_r_reg;
  assign bus.out_tag   = s3_tag_reg;

`ifdef APPROX_MULT_ERR_MON_EN
  // Exact product runs one stage behind the operands, in step with the
  // quadrant products, so the error lands in S3 alongside out_r.
  logic [2*W-1:0] s2_exact_reg;
  logic [2*W-1:0] s3_err_reg;
  logic [31:0]    err_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_exact_reg <= '0;
      s3_err_reg   <= '0;
    end else if (advance) begin
      s2_exact_reg <= {{W{1'b0}}, s1_a_reg} * {{W{1'b0}}, s1_b_reg};
      s3_err_reg   <= s2_exact_reg - sum_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (s3_valid_reg && bus.out_ready && (s3_err_reg != '0)
                 && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + 32'd1;
    end
  end

  assign err_abs = s3_err_reg;
  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe
//   Two instances: W=8/TRUNC=2 for the directed steps, W=16/TRUNC=3 for a
//   random sweep. Expected results are pushed when an operand transfer is
//   seen and popped when the matching output transfer is seen.
//   With APPROX_MULT_ERR_MON_EN defined the error outputs are also checked.
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  approx_mult_pipe_if #(.W(8),  .TAG_W(4)) b8 ();
  approx_mult_pipe_if #(.W(16), .TAG_W(8)) b16 ();

`ifdef APPROX_MULT_ERR_MON_EN
  logic [15:0] err8;
  logic [31:0] cnt8;
  logic [31:0] err16;
  logic [31:0] cnt16;
`endif

  approx_mult_pipe #(.W(8), .TRUNC(2), .TAG_W(4)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
`ifdef APPROX_MULT_ERR_MON_EN
    , .err_abs (err8), .err_cnt (cnt8)
`endif
  );

  approx_mult_pipe #(.W(16), .TRUNC(3), .TAG_W(8)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
`ifdef APPROX_MULT_ERR_MON_EN
    , .err_abs (err16), .err_cnt (cnt16)
`endif
  );

  typedef struct {
    logic [31:0] r;
    logic [7:0]  tag;
    logic [31:0] err;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8_drv;
  exp_t e16_drv;

  int n_vec = 0;
  int n_err = 0;
  int d8    = 0;
  int ecnt8 = 0;
  int ecnt16 = 0;
  logic acc8;
  logic acc16;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: loop over quadrants, placing each (possibly truncated)
  // half-product at the bit weight of its two operand halves.
  function automatic logic [31:0] model(input int w, input int tr,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] mode);
    longint unsigned acc;
    longint unsigned msk;
    longint unsigned ah;
    longint unsigned bh;
    longint unsigned p;
    int hw;
    hw  = w / 2;
    acc = 0;
    msk = (64'd1 << hw) - 1;
    for (int q = 0; q < 4; q++) begin
      ah = (64'(a) >> (hw * (q / 2))) & msk;
      bh = (64'(b) >> (hw * (q % 2))) & msk;
      p  = ah * bh;
      if (mode[q]) p = (p >> tr) << tr;
      acc = acc + (p << (hw * ((q / 2) + (q % 2))));
    end
    return acc[31:0];
  endfunction

  // One clock: sample transfers at the falling edge, return 1 time unit
  // after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc8  = b8.in_valid && b8.in_ready;
    acc16 = b16.in_valid && b16.in_ready;
    if (acc8)  q8.push_back(e8_drv);
    if (acc16) q16.push_back(e16_drv);
    if (b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        chk("sb8_nonempty", 64'(q8.size()), 64'd1);
      end else begin
        e = q8.pop_front();
        d8++;
        $display("u8  out tag=%h r=%h exp=%h", b8.out_tag, b8.out_r, e.r[15:0]);
        chk("r8", 64'(b8.out_r), 64'(e.r[15:0]));
        chk("tag8", 64'(b8.out_tag), 64'(e.tag[3:0]));
`ifdef APPROX_MULT_ERR_MON_EN
        chk("err8", 64'(err8), 64'(e.err[15:0]));
        if (e.err != 0) ecnt8++;
`endif
      end
    end
    if (b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        chk("sb16_nonempty", 64'(q16.size()), 64'd1);
      end else begin
        e = q16.pop_front();
        $display("u16 out tag=%h r=%h exp=%h", b16.out_tag, b16.out_r, e.r);
        chk("r16", 64'(b16.out_r), 64'(e.r));
        chk("tag16", 64'(b16.out_tag), 64'(e.tag));
`ifdef APPROX_MULT_ERR_MON_EN
        chk("err16", 64'(err16), 64'(e.err));
        if (e.err != 0) ecnt16++;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] mode,
                        input logic [3:0] tag, input logic [15:0] rexp);
    b8.in_a    = a;
    b8.in_b    = b;
    b8.in_mode = mode;
    b8.in_tag  = tag;
    e8_drv.r   = 32'(rexp);
    e8_drv.tag = 8'(tag);
    e8_drv.err = 32'(a) * 32'(b) - 32'(rexp);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] mode,
                       input logic [3:0] tag, input logic [15:0] rexp);
    drive8(a, b, mode, tag, rexp);
    b8.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc8) break;
    end
    chk("accept8", 64'(acc8), 64'd1);
    b8.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      cycle();
    end
    chk("drain8", 64'(q8.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);
  endtask

  logic [7:0]  ba[5];
  logic [7:0]  bb[5];
  logic [3:0]  bm[5];
  logic [15:0] held_r;
  logic [3:0]  held_tag;
  logic        held_ok;
  logic        have;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [3:0]  rm;
  int          idx;
  int          d8_start;
  int          gen_n;

  initial begin
    b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.in_mode  = MODE_EXACT;
    b8.in_tag    = '0;   b8.out_ready  = 1'b1;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_mode = MODE_EXACT;
    b16.in_tag   = '0;   b16.out_ready = 1'b1;
    e8_drv  = '{default: '0};
    e16_drv = '{default: '0};

    // Reset state
    #12;
    chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_out_r", 64'(b8.out_r), 64'd0);
    chk("rst_out_tag", 64'(b8.out_tag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(b8.in_ready), 64'd1);

    // Exact, with latency check
    send8(8'hFF, 8'hFF, MODE_EXACT, 4'h3, 16'hFE01);
    cycle();
    chk("lat_2cyc_valid", 64'(b8.out_valid), 64'd0);
    cycle();
    chk("lat_3cyc_valid", 64'(b8.out_valid), 64'd1);
    drain();

    // Approximate quadrants, zero operands
    send8(8'hFF, 8'hFF, MODE_ALL_APPROX, 4'h4, 16'hFCE0);
    send8(8'hFF, 8'hFF, 4'h1, 4'h5, 16'hFE00);
    send8(8'h12, 8'h34, 4'h8, 4'h6, 16'h00A8);
    send8(8'h00, 8'h00, MODE_ALL_APPROX, 4'h7, 16'h0000);
    send8(8'h00, 8'h00, MODE_EXACT, 4'h8, 16'h0000);
    drain();
`ifdef APPROX_MULT_ERR_MON_EN
    chk("err_cnt8", 64'(cnt8), 64'(ecnt8));
`endif

    // Backpressure: 5 ops streamed, out_ready low for 4 cycles mid-stream
    ba = '{8'h11, 8'hA5, 8'h7F, 8'hC3, 8'h5A};
    bb = '{8'h22, 8'h3C, 8'hFE, 8'h99, 8'h01};
    bm = '{4'h0, 4'hF, 4'h6, 4'h9, 4'h3};
    idx = 0;
    d8_start = d8;
    held_ok = 1'b0;
    held_r = '0;
    held_tag = '0;
    for (int c = 0; c < 40; c++) begin
      if (d8 - d8_start >= 5) break;
      b8.out_ready = !(c >= 3 && c <= 6);
      b8.in_valid  = (idx < 5);
      if (idx < 5)
        drive8(ba[idx], bb[idx], bm[idx], 4'(idx + 9),
               model(8, 2, 16'(ba[idx]), 16'(bb[idx]), bm[idx])[15:0]);
      #1;
      if (!b8.out_ready && b8.out_valid) begin
        chk("bp_in_ready", 64'(b8.in_ready), 64'd0);
        if (held_ok) begin
          chk("bp_r_stable", 64'(b8.out_r), 64'(held_r));
          chk("bp_tag_stable", 64'(b8.out_tag), 64'(held_tag));
        end else begin
          held_r   = b8.out_r;
          held_tag = b8.out_tag;
          held_ok  = 1'b1;
        end
      end
      cycle();
      if (acc8) idx++;
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    chk("bp_delivered", 64'(d8 - d8_start), 64'd5);
    chk("bp_stall_seen", 64'(held_ok), 64'd1);
    drain();

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      drive8(8'(8'h30 + k), 8'h47, 4'(k), 4'(k + 1),
             model(8, 2, 16'(8'h30 + k), 16'h0047, 4'(k))[15:0]);
      b8.in_valid = 1'b1;
      cycle();
    end
    b8.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(b8.out_valid), 64'd0);
    q8.delete();
    q16.delete();
    ecnt8 = 0;
    ecnt16 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("post_rst_idle", 64'(b8.out_valid), 64'd0);
    end
    send8(8'hFF, 8'hFF, MODE_EXACT, 4'hE, 16'hFE01);
    cycle();
    chk("post_rst_lat2", 64'(b8.out_valid), 64'd0);
    cycle();
    chk("post_rst_lat3", 64'(b8.out_valid), 64'd1);
    drain();

    // Random sweep on the 16-bit instance (first ops are zero operands)
    have = 1'b0;
    gen_n = 0;
    for (int c = 0; c < 400; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        ra = (gen_n < 4) ? 16'h0 : 16'($urandom);
        rb = (gen_n < 4) ? 16'h0 : 16'($urandom);
        rm = 4'($urandom_range(0, 15));
        b16.in_a    = ra;
        b16.in_b    = rb;
        b16.in_mode = rm;
        b16.in_tag  = 8'(gen_n);
        e16_drv.r   = model(16, 3, ra, rb, rm);
        e16_drv.tag = 8'(gen_n);
        e16_drv.err = 32'(ra) * 32'(rb) - e16_drv.r;
        gen_n++;
        have = 1'b1;
      end
      b16.in_valid  = have;
      b16.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      if (acc16) have = 1'b0;
    end
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    drain();
`ifdef APPROX_MULT_ERR_MON_EN
    chk("err_cnt16", 64'(cnt16), 64'(ecnt16));
    chk("err_cnt8_post_rst", 64'(cnt8), 64'(ecnt8));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
